// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by every inter-stage pipeline register.
//   RESET_PC / EXC_PC : out_pc after reset / after an exception flush
//                       (match Instr_Base_Addr / Exc_Handler_Addr).
//   SIDE_W and offsets: sideband layout {BD, excCode[4:0]}.
//   occ_e             : stage state, encoded directly as the occupancy count.
//   tnew_dec          : saturating Tnew decrement (never wraps below 0).
package pipe_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;

  localparam int SIDE_W       = 6;
  localparam int SIDE_BD_BIT  = 5;
  localparam int SIDE_EXC_LSB = 0;
  localparam int SIDE_EXC_W   = 5;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  function automatic int unsigned tnew_dec(input int unsigned t);
    return (t == 0) ? 0 : t - 1;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one storage entry of a pipeline stage (used as head and skid).
//   clk, reset      : clock, synchronous active-high reset (pc <= RESET_PC).
//   flush           : clears the entry and loads EXC_PC; beats load.
//   load            : capture wr_* this edge.
//   wr_pc/side/data/tnew : value to capture.
//   pc/side/data/tnew    : stored value.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W       = 128,
  parameter int          ENT_SIDE_W   = SIDE_W,
  parameter int          TNEW_W       = 3,
  parameter logic [31:0] ENT_RESET_PC = RESET_PC,
  parameter logic [31:0] ENT_EXC_PC   = EXC_PC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  load,
  input  logic [31:0]           wr_pc,
  input  logic [ENT_SIDE_W-1:0] wr_side,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [TNEW_W-1:0]     wr_tnew,
  output logic [31:0]           pc,
  output logic [ENT_SIDE_W-1:0] side,
  output logic [DATA_W-1:0]     data,
  output logic [TNEW_W-1:0]     tnew
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc   <= ENT_RESET_PC;
      side <= '0;
      data <= '0;
      tnew <= '0;
    end else if (flush) begin
      pc   <= ENT_EXC_PC;
      side <= '0;
      data <= '0;
      tnew <= '0;
    end else if (load) begin
      pc   <= wr_pc;
      side <= wr_side;
      data <= wr_data;
      tnew <= wr_tnew;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: inter-stage pipeline register with valid/ready handshake
// and a 2-entry skid buffer (head drives out_*, skid absorbs one extra entry).
//   clk, reset            : clock, synchronous active-high reset.
//   in_valid / in_ready   : upstream handshake; in_ready is registered.
//   in_pc/side/data/tnew  : entry fields; bubble turns the accepted entry into a nop.
//   flush                 : kills all entries, out_pc <= EXC_PC.
//   out_valid / out_ready : downstream handshake.
//   out_pc/side/data/tnew : head entry.
//   occupancy             : entries held (0..2); this is also the FSM state.
//
// Handshake: a transfer happens on an edge where valid and ready are both 1
// (acc = in_valid & in_ready, pop = out_valid & out_ready). A source holding
// valid keeps its fields stable until the transfer; valid never waits on ready.
// A flush cycle transfers nothing in either direction.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int          DATA_W    = 128,
  parameter int          SIDE_W    = pipe_pkg::SIDE_W,
  parameter int          TNEW_W    = 3,
  parameter int          TNEW_DEC  = 1,
  parameter logic [31:0] RESET_PC  = pipe_pkg::RESET_PC,
  parameter logic [31:0] EXC_PC    = pipe_pkg::EXC_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [SIDE_W-1:0] in_side,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [SIDE_W-1:0] out_side,
  output logic [DATA_W-1:0] out_data,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [1:0]        occupancy
);

  occ_e state_q, state_d;
  logic in_ready_q;
  logic acc, pop;
  logic head_load, skid_load, head_from_skid;

  // Transformed incoming entry (bubble -> nop that keeps pc/side).
  logic [DATA_W-1:0] ent_data;
  logic [TNEW_W-1:0] ent_tnew;

  // Skid contents and the head write mux.
  logic [31:0]       skid_pc;
  logic [SIDE_W-1:0] skid_side;
  logic [DATA_W-1:0] skid_data;
  logic [TNEW_W-1:0] skid_tnew;
  logic [31:0]       head_wr_pc;
  logic [SIDE_W-1:0] head_wr_side;
  logic [DATA_W-1:0] head_wr_data;
  logic [TNEW_W-1:0] head_wr_tnew;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != OCC_EMPTY);
  assign occupancy = state_q;
  assign acc       = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    ent_data = in_data;
    ent_tnew = in_tnew;
    if (TNEW_DEC != 0) begin
      ent_tnew = TNEW_W'(tnew_dec(32'(in_tnew)));
    end
    if (bubble) begin
      ent_data = '0;
      ent_tnew = '0;
    end
  end

  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    skid_load      = 1'b0;
    head_from_skid = 1'b0;
    case (state_q)
      OCC_EMPTY: begin
        if (acc) begin
          head_load = 1'b1;
          state_d   = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (acc && pop) begin
          head_load = 1'b1;           // pass-through, occupancy unchanged
        end else if (acc) begin
          skid_load = 1'b1;
          state_d   = OCC_TWO;
        end else if (pop) begin
          state_d   = OCC_EMPTY;      // head keeps its last value
        end
      end
      OCC_TWO: begin
        // in_ready is 0 here, so only a pop can happen.
        if (pop) begin
          head_load      = 1'b1;
          head_from_skid = 1'b1;
          state_d        = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    if (flush) begin
      state_d = OCC_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != OCC_TWO);
    end
  end

  always_comb begin
    head_wr_pc   = in_pc;
    head_wr_side = in_side;
    head_wr_data = ent_data;
    head_wr_tnew = ent_tnew;
    if (head_from_skid) begin
      head_wr_pc   = skid_pc;
      head_wr_side = skid_side;
      head_wr_data = skid_data;
      head_wr_tnew = skid_tnew;
    end
  end

  pipe_entry_reg #(
    .DATA_W(DATA_W), .ENT_SIDE_W(SIDE_W), .TNEW_W(TNEW_W),
    .ENT_RESET_PC(RESET_PC), .ENT_EXC_PC(EXC_PC)
  ) u_head (
    .clk(clk), .reset(reset), .flush(flush), .load(head_load),
    .wr_pc(head_wr_pc), .wr_side(head_wr_side),
    .wr_data(head_wr_data), .wr_tnew(head_wr_tnew),
    .pc(out_pc), .side(out_side), .data(out_data), .tnew(out_tnew)
  );

  pipe_entry_reg #(
    .DATA_W(DATA_W), .ENT_SIDE_W(SIDE_W), .TNEW_W(TNEW_W),
    .ENT_RESET_PC(RESET_PC), .ENT_EXC_PC(EXC_PC)
  ) u_skid (
    .clk(clk), .reset(reset), .flush(flush), .load(skid_load),
    .wr_pc(in_pc), .wr_side(in_side),
    .wr_data(ent_data), .wr_tnew(ent_tnew),
    .pc(skid_pc), .side(skid_side), .data(skid_data), .tnew(skid_tnew)
  );

endmodule
